// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner ids, burst sizing.
package arb_pkg;

  localparam int unsigned BURST_W       = 3;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_LDR : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, completion and memory port B signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              CpuReq;
  logic              LdrReq;
  logic [DATA_W-1:0] CpuAddr;
  logic [DATA_W-1:0] LdrAddr;
  logic [DATA_W-1:0] CpuWData;
  logic [DATA_W-1:0] LdrWData;
  logic              CpuWe;
  logic              LdrWe;
  logic              CpuGnt;
  logic              LdrGnt;
  logic              CpuRValid;
  logic              LdrRValid;
  logic [DATA_W-1:0] RData;
  logic              ErrMisalign;
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemWe;
  logic [DATA_W-1:0] MemRData;
  logic              Busy;

  modport slave (
    input  CpuReq, LdrReq, CpuAddr, LdrAddr, CpuWData, LdrWData, CpuWe, LdrWe, MemRData,
    output CpuGnt, LdrGnt, CpuRValid, LdrRValid, RData, ErrMisalign,
           MemAddr, MemWData, MemWe, Busy
  );

  modport master (
    output CpuReq, LdrReq, CpuAddr, LdrAddr, CpuWData, LdrWData, CpuWe, LdrWe, MemRData,
    input  CpuGnt, LdrGnt, CpuRValid, LdrRValid, RData, ErrMisalign,
           MemAddr, MemWData, MemWe, Busy
  );
endinterface

// File: rtl/arb_grant_sel.sv
// Picks the next owner from pending requests, last owner and burst count.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; default is CPU priority.
module arb_grant_sel
  import arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic               cpu_req,
  input  logic               ldr_req,
  input  owner_e             last_owner,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               grant_valid_c,
  output owner_e             grant_owner_c
);

  always_comb begin
    grant_valid_c = cpu_req | ldr_req;
    grant_owner_c = OWN_CPU;
    if (cpu_req && ldr_req) begin
      if (burst_cnt >= BURST_W'(MAX_BURST)) begin
        grant_owner_c = other_owner(last_owner);
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        // No grant since reset means no real last owner yet: CPU goes first.
        grant_owner_c = (burst_cnt == '0) ? OWN_CPU : other_owner(last_owner);
`else
        grant_owner_c = OWN_CPU;
`endif
      end
    end else if (ldr_req) begin
      grant_owner_c = OWN_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for shared memory port B: IDLE -> ACCESS -> RESP per access.
// Contention policy follows ARB_ROUND_ROBIN_EN (see arb_grant_sel).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [BURST_W-1:0] BURST_SAT = '1;

  state_e             state_q, state_d;
  owner_e             owner_q, last_owner_q;
  logic [BURST_W-1:0] burst_q;
  logic               we_q, misalign_q;
  logic [DATA_W-1:0]  mem_addr_q, mem_wdata_q, rdata_q;
  logic               mem_we_q, cpu_rvalid_q, ldr_rvalid_q, err_q, busy_q;

  logic               grant_valid_c;
  owner_e             grant_owner_c;
  logic               accept_c;
  logic [BURST_W-1:0] burst_next_c;
  logic [DATA_W-1:0]  sel_addr_c, sel_wdata_c;
  logic               sel_we_c;

  arb_grant_sel #(.MAX_BURST(MAX_BURST)) u_grant_sel (
    .cpu_req       (bus.CpuReq),
    .ldr_req       (bus.LdrReq),
    .last_owner    (last_owner_q),
    .burst_cnt     (burst_q),
    .grant_valid_c (grant_valid_c),
    .grant_owner_c (grant_owner_c)
  );

  // Next state, acceptance and the winning requester's payload.
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    burst_next_c = BURST_W'(1);
    sel_addr_c   = (grant_owner_c == OWN_CPU) ? bus.CpuAddr  : bus.LdrAddr;
    sel_wdata_c  = (grant_owner_c == OWN_CPU) ? bus.CpuWData : bus.LdrWData;
    sel_we_c     = (grant_owner_c == OWN_CPU) ? bus.CpuWe    : bus.LdrWe;
    if (grant_owner_c == last_owner_q) begin
      burst_next_c = (burst_q == BURST_SAT) ? burst_q : burst_q + BURST_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_c) begin
          accept_c = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_CPU;
      burst_q      <= '0;
      we_q         <= 1'b0;
      misalign_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rdata_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            owner_q      <= grant_owner_c;
            last_owner_q <= grant_owner_c;
            burst_q      <= burst_next_c;
            we_q         <= sel_we_c;
            misalign_q   <= (sel_addr_c[1:0] != 2'b00);
            mem_addr_q   <= {sel_addr_c[DATA_W-1:2], 2'b00};
            mem_wdata_q  <= sel_wdata_c;
            mem_we_q     <= sel_we_c;
          end
        end
        ST_ACCESS: begin
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          rdata_q      <= we_q ? '0 : bus.MemRData;
          cpu_rvalid_q <= (owner_q == OWN_CPU);
          ldr_rvalid_q <= (owner_q == OWN_LDR);
          err_q        <= misalign_q;
        end
        default: begin
          rdata_q      <= '0;
          cpu_rvalid_q <= 1'b0;
          ldr_rvalid_q <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  // Grants answer in the IDLE cycle itself and are held low during reset.
  assign bus.CpuGnt      = reset & accept_c & (grant_owner_c == OWN_CPU);
  assign bus.LdrGnt      = reset & accept_c & (grant_owner_c == OWN_LDR);
  assign bus.CpuRValid   = cpu_rvalid_q;
  assign bus.LdrRValid   = ldr_rvalid_q;
  assign bus.RData       = rdata_q;
  assign bus.ErrMisalign = err_q;
  assign bus.MemAddr     = mem_addr_q;
  assign bus.MemWData    = mem_wdata_q;
  assign bus.MemWe       = mem_we_q;
  assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (fixed-priority or round-robin build).
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if #(.DATA_W(32)) bus ();

  mem_port_arbiter #(.DATA_W(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CpuReq   = 1'b0;
    bus.LdrReq   = 1'b0;
    bus.CpuAddr  = '0;
    bus.LdrAddr  = '0;
    bus.CpuWData = '0;
    bus.LdrWData = '0;
    bus.CpuWe    = 1'b0;
    bus.LdrWe    = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.MemRData = 32'hDEAD_BEEF;
    reset = 1'b0;
    bus.CpuReq = 1'b1;
    bus.LdrReq = 1'b1;
    step();
    step();
    n_checks++; if (bus.CpuGnt !== 1'b0) begin n_fail++; $display("FAIL reset_cpugnt got %b exp 0", bus.CpuGnt); end
    n_checks++; if (bus.LdrGnt !== 1'b0) begin n_fail++; $display("FAIL reset_ldrgnt got %b exp 0", bus.LdrGnt); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
    n_checks++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL reset_memwe got %b exp 0", bus.MemWe); end
    n_checks++; if ({bus.CpuRValid, bus.LdrRValid, bus.ErrMisalign} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.CpuRValid, bus.LdrRValid, bus.ErrMisalign}); end
    n_checks++; if (bus.RData !== 32'h0 || bus.MemAddr !== 32'h0 || bus.MemWData !== 32'h0) begin
      n_fail++; $display("FAIL reset_buses got rdata %h addr %h wdata %h exp 0", bus.RData, bus.MemAddr, bus.MemWData); end
    idle_inputs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_cpu_read();
    bus.MemRData = 32'hDEAD_BEEF;
    bus.CpuAddr  = 32'h0000_0010;
    bus.CpuWe    = 1'b0;
    bus.CpuReq   = 1'b1;
    #1;
    n_checks++; if (bus.CpuGnt !== 1'b1 || bus.LdrGnt !== 1'b0) begin
      n_fail++; $display("FAIL rd_gnt got cpu %b ldr %b exp 1 0", bus.CpuGnt, bus.LdrGnt); end
    step();
    bus.CpuReq = 1'b0;
    #1;
    n_checks++; if (bus.MemAddr !== 32'h10 || bus.MemWe !== 1'b0) begin
      n_fail++; $display("FAIL rd_access got addr %h we %b exp 10 0", bus.MemAddr, bus.MemWe); end
    n_checks++; if (bus.Busy !== 1'b1 || bus.CpuRValid !== 1'b0) begin
      n_fail++; $display("FAIL rd_access_busy got busy %b rvalid %b exp 1 0", bus.Busy, bus.CpuRValid); end
    step();
    n_checks++; if (bus.CpuRValid !== 1'b1 || bus.RData !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rd_resp got rvalid %b rdata %h exp 1 deadbeef", bus.CpuRValid, bus.RData); end
    n_checks++; if (bus.LdrRValid !== 1'b0 || bus.ErrMisalign !== 1'b0) begin
      n_fail++; $display("FAIL rd_resp_flags got ldrrv %b err %b exp 0 0", bus.LdrRValid, bus.ErrMisalign); end
    step();
    n_checks++; if (bus.CpuRValid !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL rd_done got rvalid %b busy %b exp 0 0", bus.CpuRValid, bus.Busy); end
  endtask

  task automatic test_ldr_write();
    bus.LdrAddr  = 32'h0000_0020;
    bus.LdrWData = 32'h1234_5678;
    bus.LdrWe    = 1'b1;
    bus.LdrReq   = 1'b1;
    #1;
    n_checks++; if (bus.LdrGnt !== 1'b1 || bus.CpuGnt !== 1'b0) begin
      n_fail++; $display("FAIL wr_gnt got ldr %b cpu %b exp 1 0", bus.LdrGnt, bus.CpuGnt); end
    n_checks++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL wr_we_pre got %b exp 0", bus.MemWe); end
    step();
    bus.LdrReq = 1'b0;
    bus.LdrWe  = 1'b0;
    #1;
    n_checks++; if (bus.MemWe !== 1'b1 || bus.MemWData !== 32'h1234_5678 || bus.MemAddr !== 32'h20) begin
      n_fail++; $display("FAIL wr_access got we %b wdata %h addr %h exp 1 12345678 20", bus.MemWe, bus.MemWData, bus.MemAddr); end
    step();
    n_checks++; if (bus.MemWe !== 1'b0) begin n_fail++; $display("FAIL wr_we_post got %b exp 0", bus.MemWe); end
    n_checks++; if (bus.LdrRValid !== 1'b1 || bus.RData !== 32'h0 || bus.CpuRValid !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp got ldrrv %b rdata %h cpurv %b exp 1 0 0", bus.LdrRValid, bus.RData, bus.CpuRValid); end
    step();
    n_checks++; if (bus.LdrRValid !== 1'b0 || bus.MemWe !== 1'b0) begin
      n_fail++; $display("FAIL wr_done got ldrrv %b we %b exp 0 0", bus.LdrRValid, bus.MemWe); end
  endtask

  task automatic test_misalign();
    bus.CpuAddr = 32'h0000_0013;
    bus.CpuWe   = 1'b0;
    bus.CpuReq  = 1'b1;
    #1;
    n_checks++; if (bus.CpuGnt !== 1'b1) begin n_fail++; $display("FAIL mis_gnt got %b exp 1", bus.CpuGnt); end
    step();
    bus.CpuReq = 1'b0;
    #1;
    n_checks++; if (bus.MemAddr !== 32'h10) begin n_fail++; $display("FAIL mis_addr got %h exp 10", bus.MemAddr); end
    n_checks++; if (bus.ErrMisalign !== 1'b0) begin n_fail++; $display("FAIL mis_err_early got %b exp 0", bus.ErrMisalign); end
    step();
    n_checks++; if (bus.ErrMisalign !== 1'b1 || bus.CpuRValid !== 1'b1) begin
      n_fail++; $display("FAIL mis_resp got err %b rvalid %b exp 1 1", bus.ErrMisalign, bus.CpuRValid); end
    step();
    n_checks++; if (bus.ErrMisalign !== 1'b0) begin n_fail++; $display("FAIL mis_err_clear got %b exp 0", bus.ErrMisalign); end
  endtask

  task automatic test_burst();
    logic exp_ldr;
    logic got_ldr;
    logic found;
    idle_inputs();
    pulse_reset();
    bus.CpuAddr = 32'h100;
    bus.LdrAddr = 32'h200;
    bus.CpuReq  = 1'b1;
    bus.LdrReq  = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ldr = (k % 2) == 1;
`else
      exp_ldr = (k == 4) || (k == 9);
`endif
      found   = 1'b0;
      got_ldr = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        if (bus.CpuGnt || bus.LdrGnt) begin
          found   = 1'b1;
          got_ldr = bus.LdrGnt;
        end
        step();
      end
      n_checks++;
      if (!found) begin
        n_fail++; $display("FAIL burst_grant_%0d got no grant exp %s", k, exp_ldr ? "L" : "C");
      end else if (got_ldr !== exp_ldr) begin
        n_fail++; $display("FAIL burst_grant_%0d got %s exp %s", k, got_ldr ? "L" : "C", exp_ldr ? "L" : "C");
      end
    end
    idle_inputs();
    step();
    step();
    step();
  endtask

  task automatic test_reset_mid_access();
    bus.CpuAddr  = 32'h40;
    bus.CpuWData = 32'hCAFE_0001;
    bus.CpuWe    = 1'b1;
    bus.CpuReq   = 1'b1;
    #1;
    n_checks++; if (bus.CpuGnt !== 1'b1) begin n_fail++; $display("FAIL rst_mid_gnt got %b exp 1", bus.CpuGnt); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (bus.MemWe !== 1'b1) begin n_fail++; $display("FAIL rst_mid_we_before got %b exp 1", bus.MemWe); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.MemWe !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_abort got we %b busy %b exp 0 0", bus.MemWe, bus.Busy); end
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++; if (bus.CpuRValid !== 1'b0 || bus.LdrRValid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_rvalid got cpu %b ldr %b exp 0 0", bus.CpuRValid, bus.LdrRValid); end
    end
    reset = 1'b1;
    step();
    n_checks++; if (bus.CpuRValid !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_release got rvalid %b busy %b exp 0 0", bus.CpuRValid, bus.Busy); end
    bus.CpuAddr = 32'h44;
    bus.CpuWe   = 1'b0;
    bus.CpuReq  = 1'b1;
    #1;
    n_checks++; if (bus.CpuGnt !== 1'b1) begin n_fail++; $display("FAIL rst_mid_regnt got %b exp 1", bus.CpuGnt); end
    step();
    bus.CpuReq = 1'b0;
    #1;
    n_checks++; if (bus.MemAddr !== 32'h44) begin n_fail++; $display("FAIL rst_mid_addr got %h exp 44", bus.MemAddr); end
    step();
    n_checks++; if (bus.CpuRValid !== 1'b1 || bus.RData !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rst_mid_resp got rvalid %b rdata %h exp 1 deadbeef", bus.CpuRValid, bus.RData); end
    step();
  endtask

  task automatic test_busy_wait();
    bus.LdrAddr = 32'h80;
    bus.LdrWe   = 1'b0;
    bus.LdrReq  = 1'b1;
    #1;
    n_checks++; if (bus.LdrGnt !== 1'b1) begin n_fail++; $display("FAIL busy_ldrgnt got %b exp 1", bus.LdrGnt); end
    step();
    bus.LdrReq  = 1'b0;
    bus.CpuAddr = 32'h90;
    bus.CpuReq  = 1'b1;
    #1;
    n_checks++; if (bus.CpuGnt !== 1'b0 || bus.Busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_access got gnt %b busy %b exp 0 1", bus.CpuGnt, bus.Busy); end
    step();
    n_checks++; if (bus.CpuGnt !== 1'b0 || bus.Busy !== 1'b1 || bus.LdrRValid !== 1'b1) begin
      n_fail++; $display("FAIL busy_resp got gnt %b busy %b ldrrv %b exp 0 1 1", bus.CpuGnt, bus.Busy, bus.LdrRValid); end
    step();
    n_checks++; if (bus.CpuGnt !== 1'b1 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_idle got gnt %b busy %b exp 1 0", bus.CpuGnt, bus.Busy); end
    step();
    bus.CpuReq = 1'b0;
    #1;
    n_checks++; if (bus.MemAddr !== 32'h90) begin n_fail++; $display("FAIL busy_addr got %h exp 90", bus.MemAddr); end
    step();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();
    bus.MemRData = 32'h0;
    test_reset();
    test_cpu_read();
    test_ldr_write();
    test_misalign();
    test_burst();
    test_reset_mid_access();
    test_busy_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
